// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns, segment indices, digit count.
// No logic; latency and backpressure not applicable.
// Glyph patterns are active-high in {g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg_glyph_dec.sv
// Maps one active-high 7-segment pattern to a hex nibble plus a legal flag.
// Purely combinational, zero latency.
// No flow control; unrecognised patterns give nibble 0 and legal=0.
module seg_glyph_dec
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (pattern[SEG_G:SEG_A])
      GLYPH_0: nibble = 4'h0;
      GLYPH_1: nibble = 4'h1;
      GLYPH_2: nibble = 4'h2;
      GLYPH_3: nibble = 4'h3;
      GLYPH_4: nibble = 4'h4;
      GLYPH_5: nibble = 4'h5;
      GLYPH_6: nibble = 4'h6;
      GLYPH_7: nibble = 4'h7;
      GLYPH_8: nibble = 4'h8;
      GLYPH_9: nibble = 4'h9;
      GLYPH_A: nibble = 4'hA;
      GLYPH_B: nibble = 4'hB;
      GLYPH_C: nibble = 4'hC;
      GLYPH_D: nibble = 4'hD;
      GLYPH_E: nibble = 4'hE;
      GLYPH_F: nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds a 4-digit multiplexed 7-segment frame from sampled anode/segment lines.
// Latency: 2 sync + SETTLE cycles per digit latch; frame outputs registered one cycle after the last latch.
// No backpressure: pure observer. SEG_SCAN_DECODER_DP_EN enables decimal-point capture.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [31:0] raw,
  output logic [15:0] hex,
  output logic        hex_ok,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(SETTLE - 2);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

`ifdef SEG_SCAN_DECODER_DP_EN
  localparam logic [7:0] SEG_MASK = 8'hFF;
`else
  localparam logic [7:0] SEG_MASK = 8'h7F;
`endif

  logic [3:0]            an_s1, an_s2, an_q;
  logic [7:0]            seg_s1, seg_s2, seg_q;
  logic [CW-1:0]         settle_cnt;
  logic [TW-1:0]         to_cnt;
  logic [3:0]            mask, mask_nxt;
  logic [NUM_DIGITS-1:0][7:0] slot, slot_nxt;
  logic                  sample_ok, same, latch, complete;
  logic [1:0]            dig_idx;
  logic [NUM_DIGITS-1:0] legal;
  logic [15:0]           nib;
  logic [3:0]            dp_nxt;

  assign sample_ok = $onehot(~an_s2);
  assign same      = (an_s2 == an_q) && ((seg_s2 & SEG_MASK) == (seg_q & SEG_MASK));
  assign latch     = sample_ok && same && (settle_cnt == CNT_PRE);

  always_comb begin
    dig_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_s2[i]) dig_idx = 2'(i);
  end

  // The completing digit is merged here so it lands in the same frame.
  always_comb begin
    slot_nxt = slot;
    mask_nxt = mask;
    if (latch) begin
      slot_nxt[dig_idx] = ~seg_s2 & SEG_MASK;
      mask_nxt[dig_idx] = 1'b1;
    end
  end

  assign complete = &mask_nxt;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_glyph_dec u_dec (
      .pattern (slot_nxt[g][6:0]),
      .legal   (legal[g]),
      .nibble  (nib[4*g +: 4])
    );
    assign dp_nxt[g] = slot_nxt[g][SEG_DP];
  end

  assign stale = (to_cnt == TO_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1       <= 4'hF;
      an_s2       <= 4'hF;
      an_q        <= 4'hF;
      seg_s1      <= 8'hFF;
      seg_s2      <= 8'hFF;
      seg_q       <= 8'hFF;
      settle_cnt  <= '0;
      to_cnt      <= '0;
      mask        <= 4'h0;
      slot        <= '0;
      raw         <= 32'h0;
      hex         <= 16'h0;
      hex_ok      <= 1'b0;
      dp_out      <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_q   <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_q  <= seg_s2;

      if (!sample_ok || !same)
        settle_cnt <= '0;
      else if (settle_cnt != CNT_LAST)
        settle_cnt <= settle_cnt + 1'b1;

      slot        <= slot_nxt;
      frame_valid <= complete;
      if (complete) begin
        mask   <= 4'h0;
        raw    <= slot_nxt;
        hex    <= nib;
        hex_ok <= &legal;
        dp_out <= dp_nxt;
        to_cnt <= '0;
      end else begin
        mask <= mask_nxt;
        if (to_cnt != TO_MAX)
          to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE=16, TIMEOUT=1000.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [31:0] raw;
  logic [15:0] hex;
  logic        hex_ok;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        stale;

  int n_cmp = 0;
  int n_err = 0;
  int fv_total = 0;
  logic stale_at_fv = 1'b1;
  int base;

  seg_scan_decoder #(.SETTLE(16), .TIMEOUT(1000)) dut (
    .clk         (clk),
    .reset       (reset),
    .an          (an),
    .seg         (seg),
    .raw         (raw),
    .hex         (hex),
    .hex_ok      (hex_ok),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_total++;
      stale_at_fv = stale;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    an    = 4'hF;
    seg   = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scan(input int idx, input logic [7:0] glyph, input int cycles);
    logic [3:0] sel;
    sel = 4'hF;
    sel[idx] = 1'b0;
    an  = sel;
    seg = ~glyph;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic blank(input int cycles);
    an  = 4'hF;
    seg = 8'hFF;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 8'hFF;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_raw", raw, 32'h0);
    chk("rst_hex", {16'h0, hex}, 32'h0);
    chk("rst_hex_ok", {31'h0, hex_ok}, 32'h0);
    chk("rst_dp", {28'h0, dp_out}, 32'h0);
    chk("rst_fv", {31'h0, frame_valid}, 32'h0);
    chk("rst_stale", {31'h0, stale}, 32'h0);

    // Basic scan 0,1,2,3
    base = fv_total;
    scan(0, 8'h3F, 40);
    scan(1, 8'h06, 40);
    scan(2, 8'h5B, 40);
    scan(3, 8'h4F, 40);
    blank(10);
    chk("basic_fv_cnt", fv_total - base, 1);
    chk("basic_hex", {16'h0, hex}, 32'h3210);
    chk("basic_ok", {31'h0, hex_ok}, 32'h1);
    chk("basic_raw", raw, 32'h4F5B063F);

    // Glitch on digit 2 must not be latched
    base = fv_total;
    scan(2, 8'h06, 10);
    scan(0, 8'h71, 40);
    scan(1, 8'h71, 40);
    scan(3, 8'h71, 40);
    blank(10);
    chk("glitch_no_frame", fv_total - base, 0);
    scan(2, 8'h71, 40);
    blank(10);
    chk("glitch_fv_cnt", fv_total - base, 1);
    chk("glitch_hex", {16'h0, hex}, 32'hFFFF);
    chk("glitch_raw", raw, 32'h71717171);

    // Illegal glyph on digit 1
    base = fv_total;
    scan(0, 8'h7F, 40);
    scan(1, 8'h49, 40);
    scan(2, 8'h7F, 40);
    scan(3, 8'h7F, 40);
    blank(10);
    chk("illegal_fv_cnt", fv_total - base, 1);
    chk("illegal_hex", {16'h0, hex}, 32'h8808);
    chk("illegal_ok", {31'h0, hex_ok}, 32'h0);
    chk("illegal_raw", raw, 32'h7F7F497F);

    // Ghosting: two anodes low must latch nothing
    base = fv_total;
    an  = 4'b0011;
    seg = ~8'h3F;
    repeat (100) @(negedge clk);
    scan(0, 8'h3F, 40);
    scan(1, 8'h3F, 40);
    blank(10);
    chk("ghost_no_frame", fv_total - base, 0);
    chk("ghost_hex_held", {16'h0, hex}, 32'h8808);
    scan(2, 8'h3F, 40);
    scan(3, 8'h3F, 40);
    blank(10);
    chk("ghost_fv_cnt", fv_total - base, 1);
    chk("ghost_raw", raw, 32'h3F3F3F3F);
    chk("ghost_ok", {31'h0, hex_ok}, 32'h1);

    // Timeout boundary and recovery
    do_reset();
    repeat (999) @(negedge clk);
    chk("stale_999", {31'h0, stale}, 32'h0);
    @(negedge clk);
    chk("stale_1000", {31'h0, stale}, 32'h1);
    base = fv_total;
    scan(0, 8'h3F, 40);
    scan(1, 8'h3F, 40);
    scan(2, 8'h3F, 40);
    chk("stale_held", {31'h0, stale}, 32'h1);
    scan(3, 8'h3F, 40);
    blank(5);
    chk("stale_fv_cnt", fv_total - base, 1);
    chk("stale_at_fv", {31'h0, stale_at_fv}, 32'h0);
    chk("stale_after", {31'h0, stale}, 32'h0);

    // Decimal point lit on digit 3 only
    do_reset();
    base = fv_total;
    scan(0, 8'h3F, 40);
    scan(1, 8'h3F, 40);
    scan(2, 8'h3F, 40);
    scan(3, 8'hBF, 40);
    blank(10);
    chk("dp_fv_cnt", fv_total - base, 1);
    chk("dp_hex", {16'h0, hex}, 32'h0000);
    chk("dp_ok", {31'h0, hex_ok}, 32'h1);
`ifdef SEG_SCAN_DECODER_DP_EN
    chk("dp_out", {28'h0, dp_out}, 32'h8);
    chk("dp_raw", raw, 32'hBF3F3F3F);
`else
    chk("dp_out", {28'h0, dp_out}, 32'h0);
    chk("dp_raw", raw, 32'h3F3F3F3F);
`endif

    // Reset mid-frame discards the partial mask
    scan(0, 8'h6D, 40);
    scan(1, 8'h7D, 40);
    reset = 1'b1;
    an    = 4'hF;
    seg   = 8'hFF;
    repeat (2) @(negedge clk);
    chk("midrst_raw", raw, 32'h0);
    chk("midrst_hex", {16'h0, hex}, 32'h0);
    reset = 1'b0;
    base = fv_total;
    scan(2, 8'h07, 40);
    scan(3, 8'h6F, 40);
    blank(10);
    chk("midrst_no_frame", fv_total - base, 0);
    scan(0, 8'h6D, 40);
    scan(1, 8'h7D, 40);
    blank(10);
    chk("midrst_fv_cnt", fv_total - base, 1);
    chk("midrst_hex2", {16'h0, hex}, 32'h9765);
    chk("midrst_raw2", raw, 32'h6F077D6D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
